// File: rtl/node_stack_t30_if.sv
// Port bundle between a stack node and its four grid neighbours.
// Push: neighbour i holds sendIn[i] with in_i until doneOut[i] is high in the same cycle.
// Pop: readyOut[i] offers outData, and the neighbour answers next cycle with a one-cycle recvIn[i].
interface node_stack_t30_if;
  logic signed [10:0] in0;
  logic signed [10:0] in1;
  logic signed [10:0] in2;
  logic signed [10:0] in3;
  logic        [3:0]  sendIn;
  logic        [3:0]  doneOut;
  logic signed [10:0] outData;
  logic        [3:0]  readyOut;
  logic        [3:0]  recvIn;
  logic        [3:0]  count;

  modport slave (
    input  in0, in1, in2, in3, sendIn, recvIn,
    output doneOut, outData, readyOut, count
  );

  modport master (
    output in0, in1, in2, in3, sendIn, recvIn,
    input  doneOut, outData, readyOut, count
  );
endinterface

// File: rtl/node_stack_t30.sv
// LIFO stack node that answers neighbour pushes and pops on a grid port.
// Values are stored and returned bit-exact, and the top of stack is read combinationally.
module node_stack_t30 #(
  parameter int DEPTH = 15
) (
  input  logic              clk,
  input  logic              rst,
  node_stack_t30_if.slave   port
);

  logic signed [10:0] mem_q [DEPTH];
  logic        [3:0]  sp_q, sp_d;
  logic               pop;
  logic               can_push;
  logic        [3:0]  grant;
  logic               push;
  logic signed [10:0] push_data;
  logic        [3:0]  top_idx;

  assign pop      = |port.recvIn;
  assign top_idx  = sp_q - 4'd1;
  assign can_push = ((sp_q < 4'(DEPTH)) | pop) & ~rst;

  // Lowest-index sender wins, and the others keep send high and retry.
  always_comb begin
    grant     = 4'b0000;
    push_data = '0;
    if (can_push) begin
      if (port.sendIn[0]) begin
        grant     = 4'b0001;
        push_data = port.in0;
      end else if (port.sendIn[1]) begin
        grant     = 4'b0010;
        push_data = port.in1;
      end else if (port.sendIn[2]) begin
        grant     = 4'b0100;
        push_data = port.in2;
      end else if (port.sendIn[3]) begin
        grant     = 4'b1000;
        push_data = port.in3;
      end
    end
  end

  assign push = |grant;

  always_comb begin
    sp_d = sp_q;
    if (push && !(pop && sp_q != 4'd0)) begin
      sp_d = sp_q + 4'd1;
    end else if (!push && pop && sp_q != 4'd0) begin
      sp_d = sp_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= 4'd0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage has no reset, because sp alone defines which words are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop && sp_q != 4'd0) begin
        mem_q[top_idx] <= push_data;
      end else begin
        mem_q[sp_q] <= push_data;
      end
    end
  end

  assign port.doneOut  = grant;
  assign port.outData  = (sp_q == 4'd0) ? 11'sd0 : mem_q[top_idx];
  assign port.readyOut = {4{(sp_q != 4'd0) & ~pop & ~rst}};
  assign port.count    = sp_q;

endmodule

// File: tb/tb_node_stack_t30.sv
// Directed bench for node_stack_t30 that drives push, pop, arbitration, full and reset scenarios.
module tb_node_stack_t30;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  node_stack_t30_if port ();

  node_stack_t30 #(.DEPTH(15)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (port.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    port.sendIn = 4'b0000;
    port.recvIn = 4'b0000;
    port.in0    = '0;
    port.in1    = '0;
    port.in2    = '0;
    port.in3    = '0;
  endtask

  task automatic push0(input logic signed [10:0] v);
    port.in0    = v;
    port.sendIn = 4'b0001;
    cycle();
    port.sendIn = 4'b0000;
  endtask

  task automatic pop_once();
    port.recvIn = 4'b0001;
    cycle();
    port.recvIn = 4'b0000;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    n_total++;
    if (port.count !== 4'd0) $display("FAIL reset_count got %0d want 0", port.count);
    else n_pass++;
    n_total++;
    if (port.outData !== 11'sd0) $display("FAIL reset_out got %0d want 0", port.outData);
    else n_pass++;
    n_total++;
    if (port.readyOut !== 4'b0000) $display("FAIL reset_ready got %b want 0000", port.readyOut);
    else n_pass++;
  endtask

  task automatic test_push_three();
    logic signed [10:0] vals [3];
    vals[0] = 11'sd5;
    vals[1] = 11'sd7;
    vals[2] = -11'sd3;
    for (int i = 0; i < 3; i++) begin
      port.in0    = vals[i];
      port.sendIn = 4'b0001;
      #1;
      n_total++;
      if (port.doneOut !== 4'b0001) $display("FAIL push_done%0d got %b want 0001", i, port.doneOut);
      else n_pass++;
      cycle();
    end
    port.sendIn = 4'b0000;
    #1;
    n_total++;
    if (port.count !== 4'd3) $display("FAIL push_count got %0d want 3", port.count);
    else n_pass++;
    n_total++;
    if (port.outData !== 11'h7FD) $display("FAIL push_top got %h want 7fd", port.outData);
    else n_pass++;
    n_total++;
    if (port.readyOut !== 4'b1111) $display("FAIL push_ready got %b want 1111", port.readyOut);
    else n_pass++;
  endtask

  task automatic test_pop();
    logic signed [10:0] exp_top [3];
    logic        [3:0]  exp_cnt [3];
    exp_top[0] = 11'sd7; exp_top[1] = 11'sd5; exp_top[2] = 11'sd0;
    exp_cnt[0] = 4'd2;   exp_cnt[1] = 4'd1;   exp_cnt[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      port.recvIn = 4'b0010;
      #1;
      n_total++;
      if (port.readyOut !== 4'b0000) $display("FAIL pop_mask%0d got %b want 0000", i, port.readyOut);
      else n_pass++;
      cycle();
      port.recvIn = 4'b0000;
      #1;
      n_total++;
      if (port.outData !== exp_top[i] || port.count !== exp_cnt[i])
        $display("FAIL pop_top%0d got %0d/%0d want %0d/%0d", i, port.outData, port.count,
                 exp_top[i], exp_cnt[i]);
      else n_pass++;
    end
    n_total++;
    if (port.readyOut !== 4'b0000) $display("FAIL pop_empty_ready got %b want 0000", port.readyOut);
    else n_pass++;
    // A pop on an empty stack must leave sp at zero.
    pop_once();
    #1;
    n_total++;
    if (port.count !== 4'd0) $display("FAIL pop_underflow got %0d want 0", port.count);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int v = 1; v <= 15; v++) push0(11'(v));
    #1;
    n_total++;
    if (port.count !== 4'd15 || port.outData !== 11'sd15)
      $display("FAIL full_fill got %0d/%0d want 15/15", port.count, port.outData);
    else n_pass++;
    port.in2    = 11'sd99;
    port.sendIn = 4'b0100;
    #1;
    n_total++;
    if (port.doneOut !== 4'b0000) $display("FAIL full_block got %b want 0000", port.doneOut);
    else n_pass++;
    cycle();
    n_total++;
    if (port.count !== 4'd15 || port.doneOut !== 4'b0000)
      $display("FAIL full_hold got %0d/%b want 15/0000", port.count, port.doneOut);
    else n_pass++;
    port.recvIn = 4'b0001;
    #1;
    n_total++;
    if (port.doneOut !== 4'b0100) $display("FAIL full_poppush_done got %b want 0100", port.doneOut);
    else n_pass++;
    cycle();
    idle();
    #1;
    n_total++;
    if (port.count !== 4'd15 || port.outData !== 11'sd99)
      $display("FAIL full_replace got %0d/%0d want 15/99", port.count, port.outData);
    else n_pass++;
    pop_once();
    #1;
    n_total++;
    if (port.outData !== 11'sd14) $display("FAIL full_below got %0d want 14", port.outData);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    do_reset();
    port.in1    = 11'sd4;
    port.in3    = 11'sd8;
    port.sendIn = 4'b1010;
    #1;
    n_total++;
    if (port.doneOut !== 4'b0010) $display("FAIL arb_first got %b want 0010", port.doneOut);
    else n_pass++;
    cycle();
    port.sendIn = 4'b1000;
    #1;
    n_total++;
    if (port.doneOut !== 4'b1000) $display("FAIL arb_second got %b want 1000", port.doneOut);
    else n_pass++;
    cycle();
    port.sendIn = 4'b0000;
    #1;
    n_total++;
    if (port.count !== 4'd2 || port.outData !== 11'sd8)
      $display("FAIL arb_result got %0d/%0d want 2/8", port.count, port.outData);
    else n_pass++;
    pop_once();
    #1;
    n_total++;
    if (port.outData !== 11'sd4) $display("FAIL arb_order got %0d want 4", port.outData);
    else n_pass++;
  endtask

  task automatic test_replace();
    do_reset();
    push0(11'sd1);
    push0(11'sd2);
    port.in3    = 11'sd6;
    port.sendIn = 4'b1000;
    port.recvIn = 4'b0001;
    #1;
    n_total++;
    if (port.doneOut !== 4'b1000) $display("FAIL repl_done got %b want 1000", port.doneOut);
    else n_pass++;
    cycle();
    idle();
    #1;
    n_total++;
    if (port.count !== 4'd2 || port.outData !== 11'sd6)
      $display("FAIL repl_top got %0d/%0d want 2/6", port.count, port.outData);
    else n_pass++;
    pop_once();
    #1;
    n_total++;
    if (port.count !== 4'd1 || port.outData !== 11'sd1)
      $display("FAIL repl_bottom got %0d/%0d want 1/1", port.count, port.outData);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push0(11'sd10);
    push0(11'sd20);
    push0(11'sd30);
    port.in0    = 11'sd55;
    port.sendIn = 4'b0001;
    rst         = 1'b1;
    #1;
    n_total++;
    if (port.doneOut !== 4'b0000 || port.readyOut !== 4'b0000)
      $display("FAIL rst_mask got %b/%b want 0000/0000", port.doneOut, port.readyOut);
    else n_pass++;
    cycle();
    rst = 1'b0;
    #1;
    n_total++;
    if (port.count !== 4'd0 || port.outData !== 11'sd0 || port.readyOut !== 4'b0000)
      $display("FAIL rst_clear got %0d/%0d/%b want 0/0/0000", port.count, port.outData,
               port.readyOut);
    else n_pass++;
    n_total++;
    if (port.doneOut !== 4'b0001) $display("FAIL rst_retry got %b want 0001", port.doneOut);
    else n_pass++;
    cycle();
    port.sendIn = 4'b0000;
    #1;
    n_total++;
    if (port.count !== 4'd1 || port.outData !== 11'sd55 || port.readyOut !== 4'b1111)
      $display("FAIL rst_push got %0d/%0d/%b want 1/55/1111", port.count, port.outData,
               port.readyOut);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_push_three();
    test_pop();
    test_full();
    test_arbitration();
    test_replace();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/node_stack_t30.md
Name: node_stack_t30

Overview:
- Stack-memory node (T30 equivalent) that sits on a grid port as the far end of the node neighbour handshake.
- Neighbours push 11-bit signed values into it by driving a MOV to the port. Neighbours pop values out of it by reading the port.
- It is the responder for both directions of the node port protocol:
  - it acknowledges incoming sends with a combinational done;
  - it presents ready data and consumes the neighbour's registered recv strobe.

Parameters:
- DEPTH, 15, maximum number of stored words (1..15). The count width is fixed at 4 bits.

Ports:
- clk  input  1  clock, shared with all nodes
- rst  input  1  synchronous reset, active high
- in0  input  11  signed data from neighbour 0 (its outData)
- in1  input  11  signed data from neighbour 1
- in2  input  11  signed data from neighbour 2
- in3  input  11  signed data from neighbour 3
- sendIn  input  4  neighbour i is offering in_i (its send line toward this node)
- doneOut  output  4  push accepted from neighbour i this cycle (combinational; drives that neighbour's done)
- outData  output  11  signed top-of-stack value, 0 when empty
- readyOut  output  4  stack has data for neighbour i (drives that neighbour's ready)
- recvIn  input  4  neighbour i consumed outData (its registered recv pulse)
- count  output  4  number of stored words

Behaviour:
- Reset:
  - sp=0, count=0, outData=0, readyOut=0.
  - doneOut is forced to 0 in any cycle where rst=1. The memory array is not cleared.
- Storage: array mem[0..DEPTH-1] of 11 bits, plus stack pointer sp (0..DEPTH). sp equals count.
- Top of stack: outData = (sp==0) ? 0 : mem[sp-1]. This is a combinational read of registers, so there is no extra latency.
- Pop detection: pop = |recvIn. Neighbour recv pulses arrive one cycle after the neighbour sampled the data.
  - If more than one bit is set in the same cycle, the stack performs one pop only. That case is a protocol violation and cannot occur with a single readyOut edge.
- Ready:
  - readyOut[i] = (sp!=0) & ~pop & ~rst, for all i.
  - Masking with pop blocks re-reading of the stale top during the recv cycle.
  - The new top is visible in the cycle after the pop.
- Push arbitration:
  - grant = lowest index i with sendIn[i]=1, and only when (sp<DEPTH or pop) and ~rst.
  - doneOut has exactly one bit set (the grant), or is all zero.
  - Non-granted senders stay blocked and retry next cycle, since their send stays high.
- State update on the rising edge of clk, when not in reset:
  - pop only: sp <= sp-1. A pop when sp==0 is ignored.
  - push only: mem[sp] <= in_grant; sp <= sp+1.
  - push and pop together: mem[sp-1] <= in_grant; sp unchanged. The top is replaced.
  - push and pop together with sp==0: treat as push only.
- Full: at sp==DEPTH with no pop, doneOut=0 and all pushers block. A full stack that sees a pop in the same cycle accepts one push.
- Empty: readyOut=0 and outData=0. A push into the empty stack makes readyOut high and outData equal to the value on the next cycle.
- Latency: push accepted in cycle t gives visible top and ready at t+1. A recv seen in cycle t gives ready low at t, and the new top with ready (if not empty) at t+1.
- Reset mid-operation: sync rst discards all contents and masks done/ready in that cycle. Any in-flight neighbour send simply stays blocked.
- Arithmetic: pure storage. No sign extension or modification; values pass through bit-exact.

Test Plan:
1. Reset, then neighbour 0 pushes 5, 7, -3 in consecutive cycles → doneOut=0001 each cycle; count=3; outData=-3 (11'h7FD); readyOut=1111.
2. From scenario 1, pulse recvIn=0010 for one cycle → readyOut=0000 during the pulse; next cycle outData=7, count=2. Repeat twice → count=0, outData=0, readyOut=0000.
3. Push 15 values 1..15, then sendIn=0100 with in2=99 → doneOut=0000 and count stays 15 while held. Then recvIn=0001 in the same cycle → doneOut=0100; count stays 15; outData=99.
4. Empty stack, sendIn=1010 with in1=4, in3=8 → cycle 1 doneOut=0010 (4 stored); cycle 2 doneOut=1000 (8 stored); count=2; outData=8.
5. Stack holding {1,2}, push 6 from port 3 with recvIn=0001 in the same cycle → count=2; outData=6; mem[0]=1.
6. Stack holding 3 words, assert rst for one cycle while sendIn=0001 → doneOut=0000 during rst; next cycle count=0, outData=0, readyOut=0. The cycle after, doneOut=0001 and in0 is pushed.
